// File: rtl/pc_trace_monitor.sv
// Fetch-path run monitor: logs the last DEPTH PCs, detects ECALL/EBREAK/timeout, then dumps history oldest-first.
// Optional debug stop on STOP_PC is enabled by defining MONITOR_PC_STOP_EN.
module pc_trace_monitor #(
    parameter int               DEPTH          = 10,
    parameter int               TIMEOUT_CYCLES = 49999,
    parameter int               XLEN           = 32,
    parameter logic [XLEN-1:0]  STOP_PC        = 'ha4
) (
    input  logic            sysClk,
    input  logic            sysRes,
    input  logic            instrValid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instrData,
    output logic [2:0]      status,
    output logic            done,
    output logic            dumpValid,
    input  logic            dumpReady,
    output logic [XLEN-1:0] dumpData,
    output logic            dumpLast,
    output logic [6:0]      entryCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_STOP    = 3'd4
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [XLEN-1:0] histBuf [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [31:0]     cycleCnt;
    logic [6:0]      remaining;
    logic            dumpArmed;

    logic isEcall;
    logic isEbreak;
    logic stopHit;
    logic timeoutHit;

    assign isEcall    = instrValid && (instrData == XLEN'(32'h0000_0073));
    assign isEbreak   = instrValid && (instrData == XLEN'(32'h0010_0073));
    assign timeoutHit = (cycleCnt == 32'(TIMEOUT_CYCLES - 1));

`ifdef MONITOR_PC_STOP_EN
    assign stopHit = instrValid && (pc == STOP_PC);
`else
    logic unusedStopPc;
    assign unusedStopPc = ^STOP_PC;
    assign stopHit      = 1'b0;
`endif

    always_ff @(posedge sysClk) begin
        if (sysRes) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Trap priority: ECALL, then EBREAK, then debug stop, then timeout.
    always_comb begin
        stateNext = state;
        if (state == ST_RUN) begin
            if (isEcall) begin
                stateNext = ST_PASS;
            end else if (isEbreak) begin
                stateNext = ST_FAIL;
            end else if (stopHit) begin
                stateNext = ST_STOP;
            end else if (timeoutHit) begin
                stateNext = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        status = state;
        done   = (state != ST_RUN);
    end

    always_ff @(posedge sysClk) begin
        if (!sysRes && state == ST_RUN && instrValid) begin
            histBuf[wrPtr] <= pc;
        end
    end

    // The first terminal cycle arms the dump, so dumpValid follows done by one cycle.
    always_ff @(posedge sysClk) begin
        if (sysRes) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            entryCount <= '0;
            cycleCnt   <= '0;
            remaining  <= '0;
            dumpValid  <= 1'b0;
            dumpArmed  <= 1'b0;
        end else if (state == ST_RUN) begin
            cycleCnt <= cycleCnt + 32'd1;
            if (instrValid) begin
                wrPtr <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
                if (entryCount < 7'(DEPTH)) begin
                    entryCount <= entryCount + 7'd1;
                end
            end
        end else if (!dumpArmed) begin
            dumpArmed <= 1'b1;
            rdPtr     <= (entryCount < 7'(DEPTH)) ? '0 : wrPtr;
            remaining <= entryCount;
            dumpValid <= (entryCount != 7'd0);
        end else if (dumpValid && dumpReady) begin
            rdPtr     <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + AW'(1);
            remaining <= remaining - 7'd1;
            if (remaining == 7'd1) begin
                dumpValid <= 1'b0;
            end
        end
    end

    assign dumpData = dumpValid ? histBuf[rdPtr] : '0;
    assign dumpLast = dumpValid && (remaining == 7'd1);

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Scoreboard bench for pc_trace_monitor: directed programs push expected dump entries, a monitor pops and compares.
module tb_pc_trace_monitor;

    localparam int DEPTH   = 10;
    localparam int TIMEOUT = 20;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        sysClk = 1'b0;
    logic        sysRes = 1'b0;
    logic        instrValid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instrData = '0;
    logic [2:0]  status;
    logic        done;
    logic        dumpValid;
    logic        dumpReady = 1'b1;
    logic [31:0] dumpData;
    logic        dumpLast;
    logic [6:0]  entryCount;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    pc_trace_monitor #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .XLEN(32),
        .STOP_PC(32'ha4)
    ) dut (
        .sysClk(sysClk),
        .sysRes(sysRes),
        .instrValid(instrValid),
        .pc(pc),
        .instrData(instrData),
        .status(status),
        .done(done),
        .dumpValid(dumpValid),
        .dumpReady(dumpReady),
        .dumpData(dumpData),
        .dumpLast(dumpLast),
        .entryCount(entryCount)
    );

    always #5 sysClk = ~sysClk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] fetchPc, input logic [31:0] word);
        instrValid = 1'b1;
        pc         = fetchPc;
        instrData  = word;
        tick();
        instrValid = 1'b0;
    endtask

    task automatic pushExp(input logic [31:0] data, input logic last);
        expQ.push_back('{data: data, last: last});
    endtask

    task automatic doReset();
        sysRes = 1'b1;
        expQ.delete();
        tick();
        tick();
        checkOutput("reset_status", 32'(status), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dumpValid", 32'(dumpValid), 32'd0);
        checkOutput("reset_dumpData", dumpData, 32'd0);
        checkOutput("reset_dumpLast", 32'(dumpLast), 32'd0);
        checkOutput("reset_entryCount", 32'(entryCount), 32'd0);
        sysRes = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (expQ.size() == 0 && !dumpValid) break;
            tick();
        end
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
        repeat (3) tick();
        checkOutput({name, "_dumpValid_off"}, 32'(dumpValid), 32'd0);
    endtask

    // Monitor: samples mid-cycle, pops on a completed handshake and checks stalled data holds.
    logic        stalled = 1'b0;
    logic [31:0] heldData = '0;
    always @(negedge sysClk) begin
        if (sysRes) begin
            stalled = 1'b0;
        end else if (dumpValid) begin
            if (stalled) checkOutput("stall_hold", dumpData, heldData);
            if (dumpReady) begin
                stalled = 1'b0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_entry", dumpData, 32'hdead_beef);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("dump_data", dumpData, e.data);
                    checkOutput("dump_last", 32'(dumpLast), 32'(e.last));
                end
            end else begin
                stalled  = 1'b1;
                heldData = dumpData;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        tick();

        // Test 1: short program ending in ECALL
        doReset();
        pushExp(32'h0, 1'b0); pushExp(32'h4, 1'b0); pushExp(32'h8, 1'b0); pushExp(32'hC, 1'b1);
        applyStimulus(32'h0, NOP);
        applyStimulus(32'h4, NOP);
        applyStimulus(32'h8, NOP);
        checkOutput("t1_still_run", 32'(status), 32'd0);
        applyStimulus(32'hC, ECALL);
        checkOutput("t1_status", 32'(status), 32'd1);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_entryCount", 32'(entryCount), 32'd4);
        checkOutput("t1_valid_delay", 32'(dumpValid), 32'd0);
        waitDrain("t1", 50);
        applyStimulus(32'h40, EBREAK);
        checkOutput("t1_sticky_status", 32'(status), 32'd1);
        checkOutput("t1_no_log", 32'(entryCount), 32'd4);

        // Test 2: history wraps, EBREAK after 15 fetches
        doReset();
        for (int i = 6; i < 16; i++) pushExp(32'(i * 4), i == 15);
        for (int i = 0; i < 15; i++) applyStimulus(32'(i * 4), NOP);
        applyStimulus(32'h3C, EBREAK);
        checkOutput("t2_status", 32'(status), 32'd2);
        checkOutput("t2_entryCount", 32'(entryCount), 32'd10);
        waitDrain("t2", 60);

        // Test 3a: timeout with no fetches, nothing to dump
        doReset();
        repeat (TIMEOUT - 1) tick();
        checkOutput("t3_pre_timeout", 32'(status), 32'd0);
        tick();
        checkOutput("t3_timeout", 32'(status), 32'd3);
        repeat (5) tick();
        checkOutput("t3_empty_dump", 32'(dumpValid), 32'd0);

        // Test 3b/3c: trap on the final budget cycle beats timeout
        doReset();
        pushExp(32'h80, 1'b1);
        repeat (TIMEOUT - 1) tick();
        applyStimulus(32'h80, ECALL);
        checkOutput("t3_trap_wins_pass", 32'(status), 32'd1);
        waitDrain("t3b", 20);
        doReset();
        pushExp(32'h84, 1'b1);
        repeat (TIMEOUT - 1) tick();
        applyStimulus(32'h84, EBREAK);
        checkOutput("t3_trap_wins_fail", 32'(status), 32'd2);
        waitDrain("t3c", 20);

        // Test 4: dump under toggling backpressure
        doReset();
        for (int i = 0; i < 5; i++) pushExp(32'h100 + 32'(i * 4), i == 4);
        for (int i = 0; i < 4; i++) applyStimulus(32'h100 + 32'(i * 4), NOP);
        applyStimulus(32'h110, ECALL);
        for (int i = 0; i < 40 && (expQ.size() != 0 || dumpValid); i++) begin
            dumpReady = ~dumpReady;
            tick();
        end
        dumpReady = 1'b1;
        waitDrain("t4", 20);

        // Test 5: reset in the middle of a dump, then a fresh run
        doReset();
        for (int i = 0; i < 4; i++) pushExp(32'h300 + 32'(i * 4), i == 3);
        for (int i = 0; i < 3; i++) applyStimulus(32'h300 + 32'(i * 4), NOP);
        applyStimulus(32'h30C, ECALL);
        for (int i = 0; i < 20 && expQ.size() > 2; i++) tick();
        checkOutput("t5_mid_dump", 32'(expQ.size()), 32'd2);
        doReset();
        checkOutput("t5_after_valid", 32'(dumpValid), 32'd0);
        checkOutput("t5_after_count", 32'(entryCount), 32'd0);
        pushExp(32'h200, 1'b0); pushExp(32'h204, 1'b1);
        applyStimulus(32'h200, NOP);
        applyStimulus(32'h204, ECALL);
        checkOutput("t5_fresh_count", 32'(entryCount), 32'd2);
        waitDrain("t5", 20);

        // Test 6: debug stop address
        doReset();
`ifdef MONITOR_PC_STOP_EN
        pushExp(32'ha0, 1'b0); pushExp(32'ha4, 1'b1);
        applyStimulus(32'ha0, NOP);
        applyStimulus(32'ha4, NOP);
        checkOutput("t6_stop", 32'(status), 32'd4);
`else
        pushExp(32'ha0, 1'b0); pushExp(32'ha4, 1'b0); pushExp(32'ha8, 1'b1);
        applyStimulus(32'ha0, NOP);
        applyStimulus(32'ha4, NOP);
        checkOutput("t6_no_stop", 32'(status), 32'd0);
        applyStimulus(32'ha8, ECALL);
        checkOutput("t6_pass", 32'(status), 32'd1);
`endif
        waitDrain("t6", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
